// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and default bit period.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; resets to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rxer.sv
// 8N1 UART receiver with mid-bit sampling. Define UART_RX_PARITY_EN for an even-parity bit
// between D7 and stop.
module uart_rxer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       res,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       en_data_out,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HalfLast = CW'(HALF - 1);
  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IdxLast  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (res),
    .d     (RX),
    .q     (rx_s)
  );

  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           en_q, en_d;
  logic           ferr_q, ferr_d;
  logic           par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic perr_q, perr_d;
  // Even parity: data bits plus parity bit carry an even number of ones.
  assign par_bad = ^{shift_q, par_bit_q};
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    en_d      = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d  = '0;
          data_d = shift_q;
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad;
`endif
          if (rx_s) begin
            en_d    = !par_bad;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitIdle: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      en_q      <= en_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out    = data_q;
  assign en_data_out = en_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rxer.sv
// Self-checking bench for uart_rxer: frames are sent bit-serially and output pulses are
// compared with cycle numbers derived from the mid-bit sampling latency formula.
module tb_uart_rxer;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_OFF = 10 * CPB;
`else
  localparam int STOP_OFF = 9 * CPB;
`endif
  // RX set in cycle n: 2 sync cycles to t0, stop sample at t0+HALF+STOP_OFF, output one later.
  localparam int LAT   = 2 + HALF + STOP_OFF + 1;
  localparam int HSIZE = 32768;

  logic       clk;
  logic       res;
  logic       RX;
  logic [7:0] data_out;
  logic       en_data_out;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rxer #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .res         (res),
    .RX          (RX),
    .data_out    (data_out),
    .en_data_out (en_data_out),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed pulses.
  logic [7:0] en_dat[$];
  int         en_cyc[$];
  logic [7:0] fe_dat[$];
  int         fe_cyc[$];
  logic [7:0] pe_dat[$];
  int         pe_cyc[$];
  bit         busy_hist[HSIZE];
  // Expected good frames.
  logic [7:0] ex_dat[$];
  int         ex_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      if (cyc < HSIZE) busy_hist[cyc] = busy;
      if (en_data_out) begin en_dat.push_back(data_out); en_cyc.push_back(cyc); end
      if (frame_err)   begin fe_dat.push_back(data_out); fe_cyc.push_back(cyc); end
      if (parity_err)  begin pe_dat.push_back(data_out); pe_cyc.push_back(cyc); end
    end
  end

  task automatic clear_obs();
    en_dat.delete(); en_cyc.delete(); fe_dat.delete(); fe_cyc.delete();
    pe_dat.delete(); pe_cyc.delete(); ex_dat.delete(); ex_cyc.delete();
  endtask

  task automatic idle_cycles(input int k);
    RX = 1'b1;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input logic v);
    RX = v;
    repeat (CPB) begin @(posedge clk); #1; end
  endtask

  // Sends one well-formed frame; n is the cycle in which the start bit was put on RX.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, output int n);
    n = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) drive_bit(1'b1);  // extra idle-level bit time only
`endif
    drive_bit(1'b1);
  endtask

  task automatic test_reset();
    res = 1'b0;
    RX  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks += 5;
    if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", data_out); end
    if (en_data_out !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", en_data_out); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b exp 0", frame_err); end
    if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr got %b exp 0", parity_err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    res = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_single();
    int n;
    clear_obs();
    send_frame(8'h0a, 1'b0, n);
    idle_cycles(8);
    checks += 5;
    if (en_dat.size() != 1 || fe_cyc.size() != 0 || pe_cyc.size() != 0) begin
      errors++;
      $display("FAIL single_count en %0d fe %0d pe %0d exp 1 0 0",
               en_dat.size(), fe_cyc.size(), pe_cyc.size());
    end else if (en_dat[0] !== 8'h0a || en_cyc[0] != n + LAT) begin
      errors++;
      $display("FAIL single_frame got %h@%0d exp 0a@%0d", en_dat[0], en_cyc[0], n + LAT);
    end
    if (busy_hist[n+2] !== 1'b0 || busy_hist[n+3] !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_rise got %b%b exp 01", busy_hist[n+2], busy_hist[n+3]);
    end
    if (busy_hist[n+LAT-1] !== 1'b1 || busy_hist[n+LAT] !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall got %b%b exp 10", busy_hist[n+LAT-1], busy_hist[n+LAT]);
    end
    if (data_out !== 8'h0a) begin errors++; $display("FAIL single_hold got %h exp 0a", data_out); end
    if (en_data_out !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", en_data_out); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] b;
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      b = (i == 0) ? 8'h55 : (i == 1) ? 8'hAA : 8'($urandom);
      send_frame(b, 1'b0, n);
      ex_dat.push_back(b);
      ex_cyc.push_back(n + LAT);
    end
    idle_cycles(8);
    checks++;
    if (en_dat.size() != ex_dat.size() || fe_cyc.size() != 0 || pe_cyc.size() != 0) begin
      errors++;
      $display("FAIL b2b_count en %0d fe %0d pe %0d exp %0d 0 0",
               en_dat.size(), fe_cyc.size(), pe_cyc.size(), ex_dat.size());
    end
    for (int i = 0; i < ex_dat.size() && i < en_dat.size(); i++) begin
      checks++;
      if (en_dat[i] !== ex_dat[i] || en_cyc[i] != ex_cyc[i]) begin
        errors++;
        $display("FAIL b2b_frame%0d got %h@%0d exp %h@%0d",
                 i, en_dat[i], en_cyc[i], ex_dat[i], ex_cyc[i]);
      end
    end
  endtask

  task automatic test_random_gaps();
    int n;
    logic [7:0] b;
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      idle_cycles($urandom_range(0, 3 * CPB));
      b = 8'($urandom);
      send_frame(b, 1'b0, n);
      ex_dat.push_back(b);
      ex_cyc.push_back(n + LAT);
    end
    idle_cycles(8);
    checks++;
    if (en_dat.size() != ex_dat.size() || fe_cyc.size() != 0 || pe_cyc.size() != 0) begin
      errors++;
      $display("FAIL gaps_count en %0d fe %0d exp %0d 0", en_dat.size(), fe_cyc.size(),
               ex_dat.size());
    end
    for (int i = 0; i < ex_dat.size() && i < en_dat.size(); i++) begin
      checks++;
      if (en_dat[i] !== ex_dat[i] || en_cyc[i] != ex_cyc[i]) begin
        errors++;
        $display("FAIL gaps_frame%0d got %h@%0d exp %h@%0d",
                 i, en_dat[i], en_cyc[i], ex_dat[i], ex_cyc[i]);
      end
    end
  endtask

  task automatic test_glitch();
    int n;
    clear_obs();
    n  = cyc;
    RX = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    idle_cycles(3 * CPB);
    checks += 3;
    if (en_dat.size() + fe_cyc.size() + pe_cyc.size() != 0) begin
      errors++;
      $display("FAIL glitch_outputs got %0d pulses exp 0",
               en_dat.size() + fe_cyc.size() + pe_cyc.size());
    end
    if (busy_hist[n+3] !== 1'b1 || busy_hist[n+2+HALF] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_high got %b%b exp 11", busy_hist[n+3], busy_hist[n+2+HALF]);
    end
    if (busy_hist[n+2+HALF+1] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_fall got %b exp 0", busy_hist[n+2+HALF+1]);
    end
  endtask

  task automatic test_frame_err();
    int n;
    int n2;
    clear_obs();
    n = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b0);  // correct even parity for 8'hFF
`endif
    drive_bit(1'b0);
    drive_bit(1'b0);
    idle_cycles(CPB);
    send_frame(8'h3C, 1'b0, n2);
    idle_cycles(8);
    checks += 3;
    if (fe_cyc.size() != 1 || pe_cyc.size() != 0) begin
      errors++;
      $display("FAIL ferr_count got %0d/%0d exp 1/0", fe_cyc.size(), pe_cyc.size());
    end else if (fe_dat[0] !== 8'hFF || fe_cyc[0] != n + LAT) begin
      errors++;
      $display("FAIL ferr_pulse got %h@%0d exp ff@%0d", fe_dat[0], fe_cyc[0], n + LAT);
    end
    if (en_dat.size() != 1) begin
      errors++;
      $display("FAIL ferr_en_count got %0d exp 1", en_dat.size());
    end else if (en_dat[0] !== 8'h3C || en_cyc[0] != n2 + LAT) begin
      errors++;
      $display("FAIL ferr_next got %h@%0d exp 3c@%0d", en_dat[0], en_cyc[0], n2 + LAT);
    end
    if (data_out !== 8'h3C) begin errors++; $display("FAIL ferr_hold got %h exp 3c", data_out); end
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    logic [7:0] b;
    clear_obs();
    b = 8'($urandom);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    res = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      RX = 1'($urandom);
      @(negedge clk);
      if ({data_out, en_data_out, frame_err, parity_err, busy} !== 12'h000) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_outputs got %0d nonzero exp 0", bad); end
    RX  = 1'b1;
    res = 1'b1;
    idle_cycles(2 * CPB);
    send_frame(8'hC3, 1'b0, n);
    idle_cycles(8);
    checks += 2;
    if (en_dat.size() != 1 || fe_cyc.size() != 0 || pe_cyc.size() != 0) begin
      errors++;
      $display("FAIL midrst_count en %0d fe %0d pe %0d exp 1 0 0",
               en_dat.size(), fe_cyc.size(), pe_cyc.size());
    end
    if (en_dat.size() < 1 || en_dat[0] !== 8'hC3 || en_cyc[0] != n + LAT) begin
      errors++;
      $display("FAIL midrst_frame got %0d pulses first %h exp c3@%0d",
               en_dat.size(), (en_dat.size() > 0) ? en_dat[0] : 8'h00, n + LAT);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int n;
    logic [7:0] b;
    logic       flip;
    int         exp_en;
    int         exp_pe;
    clear_obs();
    exp_en = 0;
    exp_pe = 0;
    for (int i = 0; i < 8; i++) begin
      b    = (i < 2) ? 8'h07 : 8'($urandom);
      flip = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom);
      send_frame(b, flip, n);
      if (flip) exp_pe++; else exp_en++;
      checks++;
      if (flip) begin
        if (pe_cyc.size() != exp_pe || en_dat.size() != exp_en ||
            pe_dat[exp_pe-1] !== b || pe_cyc[exp_pe-1] != n + LAT) begin
          errors++;
          $display("FAIL parity_bad%0d pe %0d en %0d exp %0d %0d data %h", i,
                   pe_cyc.size(), en_dat.size(), exp_pe, exp_en, b);
        end
      end else begin
        if (en_dat.size() != exp_en || pe_cyc.size() != exp_pe ||
            en_dat[exp_en-1] !== b || en_cyc[exp_en-1] != n + LAT) begin
          errors++;
          $display("FAIL parity_good%0d pe %0d en %0d exp %0d %0d data %h", i,
                   pe_cyc.size(), en_dat.size(), exp_pe, exp_en, b);
        end
      end
    end
    checks++;
    if (fe_cyc.size() != 0) begin errors++; $display("FAIL parity_ferr got %0d exp 0", fe_cyc.size()); end
  endtask
`endif

  initial begin
    res = 1'b0;
    RX  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_random_gaps();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
